aes_key_expander: RTL and testbench

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_key_expander_if.sv | 24 ++
 rtl/aes_key_expander_word.sv | 38 +++
 rtl/sbox.sv | 41 ++++
 rtl/aes_key_expander.sv | 188 ++++++++++++++++++
 tb/tb_aes_key_expander.sv | 310 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: key length encodings, Nk/Nr lookup, Rcon arithmetic.
// Pure declarations; no latency or flow-control behaviour of its own.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128     = 2'd0,
        KEY_192     = 2'd1,
        KEY_256     = 2'd2,
        KEY_INVALID = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_DRAIN = 2'd2
    } kx_state_e;

    localparam logic [7:0] RCON_POLY = 8'h1B;
    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KEY_128: nk_of = 4'd4;
            KEY_192: nk_of = 4'd6;
            KEY_256: nk_of = 4'd8;
            default: nk_of = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KEY_128: nr_of = 4'd10;
            KEY_192: nr_of = 4'd12;
            KEY_256: nr_of = 4'd14;
            default: nr_of = 4'd0;
        endcase
    endfunction

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-in / round-key-out handshake bundle; slave = expander, master = key source and round-key sink.
// Both directions use valid/ready; key_err is an unhandshaked one-cycle pulse.
interface aes_key_expander_if;
    logic [255:0] key_in;
    logic [1:0]   key_len;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         rk_valid;
    logic         rk_ready;
    logic         key_err;

    modport master (
        output key_in, key_len, key_valid, rk_ready,
        input  key_ready, rk_data, rk_idx, rk_last, rk_valid, key_err
    );

    modport slave (
        input  key_in, key_len, key_valid, rk_ready,
        output key_ready, rk_data, rk_idx, rk_last, rk_valid, key_err
    );
endinterface

// File: rtl/aes_key_expander_word.sv
// Next expanded word: key word pass-through, or w[i-Nk] ^ t with one shared SubWord for both cases.
// Combinational, no flow control.
module aes_key_expander_word
    import aes_pkg::*;
(
    input  logic [31:0] prev_word,
    input  logic [31:0] old_word,
    input  logic        key_phase,
    input  logic        rot_sub,
    input  logic        sub_only,
    input  logic [7:0]  rcon,
    output logic [31:0] new_word
);

    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] t;

    assign sub_in = rot_sub ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox u_sbox (
            .in_byte  (sub_in[8*b +: 8]),
            .out_byte (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        t = prev_word;
        if (rot_sub) begin
            t = sub_out ^ {rcon, 24'h000000};
        end else if (sub_only) begin
            t = sub_out;
        end
        new_word = key_phase ? old_word : (old_word ^ t);
    end

endmodule

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Purely combinational, no flow control.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128, which is the inverse (and maps 0 to 0)
    always_comb begin
        sq  = in_byte;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key schedule: one word per cycle into a 4-word assembler, round keys out on valid/ready.
// First round key 5 cycles after accept, then one per 4 cycles; word generation freezes when both buffers are full.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    aes_key_expander_if.slave kx
);

    localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

    kx_state_e    state_q, state_d;
    logic [31:0]  win_q [MAX_NK];
    logic [31:0]  win_d [MAX_NK];
    logic [3:0]   nk_q, nk_d;
    logic [3:0]   nr_q, nr_d;
    logic [5:0]   word_q, word_d;
    logic [3:0]   mod_q, mod_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  asm_q [4];
    logic [31:0]  asm_d [4];
    logic [2:0]   asm_cnt_q, asm_cnt_d;
    logic [3:0]   asm_idx_q, asm_idx_d;
    logic [127:0] rk_data_q, rk_data_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic         rk_last_q, rk_last_d;
    logic         rk_valid_q, rk_valid_d;
    logic         key_err_q, key_err_d;

    logic         accept, supported, fire, out_free, asm_full, stall, gen;
    logic         key_phase, rot_sub, sub_only;
    logic [31:0]  prev_word, new_word;
    logic [5:0]   last_word;

    always_comb begin
        accept    = (state_q == ST_IDLE) && kx.key_valid;
        supported = (kx.key_len != KEY_INVALID) && (nk_of(kx.key_len) <= MAX_NK_W);
        fire      = rk_valid_q && kx.rk_ready;
        out_free  = !rk_valid_q || kx.rk_ready;
        asm_full  = (asm_cnt_q == 3'd4);
        stall     = asm_full && !out_free;
        gen       = (state_q == ST_GEN) && !stall;
        key_phase = (word_q < {2'b00, nk_q});
        rot_sub   = !key_phase && (mod_q == 4'd0);
        sub_only  = !key_phase && (nk_q == 4'd8) && (mod_q == 4'd4);
        last_word = {nr_q, 2'b11};
        prev_word = win_q[0];
        for (int j = 0; j < MAX_NK; j++) begin
            if (4'(j) == nk_q - 4'd1) prev_word = win_q[j];
        end
    end

    aes_key_expander_word u_word (
        .prev_word (prev_word),
        .old_word  (win_q[0]),
        .key_phase (key_phase),
        .rot_sub   (rot_sub),
        .sub_only  (sub_only),
        .rcon      (rcon_q),
        .new_word  (new_word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && supported)         state_d = ST_GEN;
            ST_GEN:   if (gen && word_q == last_word)  state_d = ST_DRAIN;
            ST_DRAIN: if (fire && rk_last_q)           state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        kx.key_ready = (state_q == ST_IDLE);
        kx.rk_data   = rk_data_q;
        kx.rk_idx    = rk_idx_q;
        kx.rk_last   = rk_last_q;
        kx.rk_valid  = rk_valid_q;
        kx.key_err   = key_err_q;
    end

    // Window holds w[i-Nk..i-1] oldest-first; the key words rotate through it once before expansion starts
    always_comb begin
        win_d      = win_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        word_d     = word_q;
        mod_d      = mod_q;
        rcon_d     = rcon_q;
        asm_d      = asm_q;
        asm_cnt_d  = asm_cnt_q;
        asm_idx_d  = asm_idx_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        rk_last_d  = rk_last_q;
        rk_valid_d = rk_valid_q && !kx.rk_ready;
        key_err_d  = accept && !supported;

        if (accept && supported) begin
            for (int j = 0; j < MAX_NK; j++) win_d[j] = kx.key_in[255-32*j -: 32];
            nk_d      = nk_of(kx.key_len);
            nr_d      = nr_of(kx.key_len);
            word_d    = 6'd0;
            mod_d     = 4'd0;
            rcon_d    = RCON_INIT;
            asm_cnt_d = 3'd0;
        end

        if (gen) begin
            for (int j = 0; j < MAX_NK - 1; j++) win_d[j] = win_q[j+1];
            for (int j = 0; j < MAX_NK; j++) begin
                if (4'(j) == nk_q - 4'd1) win_d[j] = new_word;
            end
            word_d = word_q + 6'd1;
            mod_d  = (mod_q == nk_q - 4'd1) ? 4'd0 : mod_q + 4'd1;
            if (rot_sub) rcon_d = xtime(rcon_q);
        end

        if (asm_full && out_free) begin
            rk_data_d  = {asm_q[0], asm_q[1], asm_q[2], asm_q[3]};
            rk_idx_d   = asm_idx_q;
            rk_last_d  = (asm_idx_q == nr_q);
            rk_valid_d = 1'b1;
            asm_cnt_d  = 3'd0;
        end

        // Completing word bypasses the assembler when the output register is free
        if (gen) begin
            if (asm_cnt_d == 3'd3 && out_free) begin
                rk_data_d  = {asm_q[0], asm_q[1], asm_q[2], new_word};
                rk_idx_d   = word_q[5:2];
                rk_last_d  = (word_q[5:2] == nr_q);
                rk_valid_d = 1'b1;
                asm_cnt_d  = 3'd0;
            end else begin
                asm_d[asm_cnt_d[1:0]] = new_word;
                asm_cnt_d             = asm_cnt_d + 3'd1;
                asm_idx_d             = word_q[5:2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int j = 0; j < MAX_NK; j++) win_q[j] <= '0;
            for (int j = 0; j < 4; j++) asm_q[j] <= '0;
            nk_q       <= '0;
            nr_q       <= '0;
            word_q     <= '0;
            mod_q      <= '0;
            rcon_q     <= '0;
            asm_cnt_q  <= '0;
            asm_idx_q  <= '0;
            rk_data_q  <= '0;
            rk_idx_q   <= '0;
            rk_last_q  <= 1'b0;
            rk_valid_q <= 1'b0;
            key_err_q  <= 1'b0;
        end else begin
            win_q      <= win_d;
            asm_q      <= asm_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            word_q     <= word_d;
            mod_q      <= mod_d;
            rcon_q     <= rcon_d;
            asm_cnt_q  <= asm_cnt_d;
            asm_idx_q  <= asm_idx_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            rk_last_q  <= rk_last_d;
            rk_valid_q <= rk_valid_d;
            key_err_q  <= key_err_d;
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 vectors, timing, backpressure, errors and mid-run reset.
module tb_aes_key_expander;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    aes_key_expander_if bus ();
    aes_key_expander_if bus4 ();

    aes_key_expander #(.MAX_NK(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kx      (bus)
    );

    aes_key_expander #(.MAX_NK(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .kx      (bus4)
    );

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_01234567_89abcdef_cafef00d};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffff_0000_a5a5_5a5a};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] EXP128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // Offers a key for exactly one edge; call at posedge+#1 while the DUT is idle
    task automatic send_key(input logic [255:0] k, input logic [1:0] len);
        bus.key_in    = k;
        bus.key_len   = len;
        bus.key_valid = 1'b1;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid got=%b exp=0", bus.rk_valid); end
        checks++; if (bus.rk_data !== 128'h0) begin errors++; $display("FAIL reset_rk_data got=%h exp=0", bus.rk_data); end
        checks++; if (bus.rk_idx !== 4'd0) begin errors++; $display("FAIL reset_rk_idx got=%0d exp=0", bus.rk_idx); end
        checks++; if (bus.rk_last !== 1'b0) begin errors++; $display("FAIL reset_rk_last got=%b exp=0", bus.rk_last); end
        checks++; if (bus.key_err !== 1'b0) begin errors++; $display("FAIL reset_key_err got=%b exp=0", bus.key_err); end
        checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got=%b exp=1", bus.key_ready); end
        checks++; if (bus4.rk_valid !== 1'b0) begin errors++; $display("FAIL reset_dut4_rk_valid got=%b exp=0", bus4.rk_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_aes128();
        int cyc = 1;
        int got = 0;
        bus.rk_ready = 1'b1;
        send_key(KEY128, 2'd0);
        for (int n = 0; n < 80 && got < 11; n++) begin
            @(negedge clk);
            if (cyc == 3) begin
                checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL a128_busy_ready got=%b exp=0", bus.key_ready); end
            end
            if (bus.rk_valid) begin
                checks++; if (bus.rk_idx !== 4'(got)) begin errors++; $display("FAIL a128_idx got=%0d exp=%0d", bus.rk_idx, got); end
                checks++; if (cyc != 4*got+5) begin errors++; $display("FAIL a128_cycle r=%0d got=%0d exp=%0d", got, cyc, 4*got+5); end
                checks++; if (bus.rk_data !== EXP128[got]) begin errors++; $display("FAIL a128_data r=%0d got=%h exp=%h", got, bus.rk_data, EXP128[got]); end
                checks++; if (bus.rk_last !== (got == 10)) begin errors++; $display("FAIL a128_last r=%0d got=%b", got, bus.rk_last); end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (got != 11) begin errors++; $display("FAIL a128_count got=%0d exp=11", got); end
        @(negedge clk);
        checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL a128_done_ready got=%b exp=1", bus.key_ready); end
        checks++; if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL a128_done_valid got=%b exp=0", bus.rk_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_aes192();
        int cyc = 1;
        int got = 0;
        bus.rk_ready = 1'b1;
        send_key(KEY192, 2'd1);
        for (int n = 0; n < 100 && got < 13; n++) begin
            @(negedge clk);
            if (bus.rk_valid) begin
                checks++; if (bus.rk_idx !== 4'(got)) begin errors++; $display("FAIL a192_idx got=%0d exp=%0d", bus.rk_idx, got); end
                checks++; if (bus.rk_last !== (got == 12)) begin errors++; $display("FAIL a192_last r=%0d got=%b", got, bus.rk_last); end
                if (got == 0) begin
                    checks++; if (bus.rk_data !== 128'h8e73b0f7da0e6452c810f32b809079e5) begin errors++; $display("FAIL a192_r0 got=%h", bus.rk_data); end
                end
                if (got == 12) begin
                    checks++; if (bus.rk_data !== 128'he98ba06f448c773c8ecc720401002202) begin errors++; $display("FAIL a192_r12 got=%h exp=e98ba06f448c773c8ecc720401002202", bus.rk_data); end
                    checks++; if (cyc != 53) begin errors++; $display("FAIL a192_cycle got=%0d exp=53", cyc); end
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (got != 13) begin errors++; $display("FAIL a192_count got=%0d exp=13", got); end
    endtask

    task automatic test_aes256();
        int got = 0;
        bus.rk_ready = 1'b1;
        send_key(KEY256, 2'd2);
        for (int n = 0; n < 100 && got < 15; n++) begin
            @(negedge clk);
            if (bus.rk_valid) begin
                checks++; if (bus.rk_idx !== 4'(got)) begin errors++; $display("FAIL a256_idx got=%0d exp=%0d", bus.rk_idx, got); end
                if (got == 0) begin
                    checks++; if (bus.rk_data !== 128'h603deb1015ca71be2b73aef0857d7781) begin errors++; $display("FAIL a256_r0 got=%h", bus.rk_data); end
                end
                if (got == 1) begin
                    checks++; if (bus.rk_data !== 128'h1f352c073b6108d72d9810a30914dff4) begin errors++; $display("FAIL a256_r1 got=%h", bus.rk_data); end
                end
                if (got == 14) begin
                    checks++; if (bus.rk_data !== 128'hfe4890d1e6188d0b046df344706c631e) begin errors++; $display("FAIL a256_r14 got=%h exp=fe4890d1e6188d0b046df344706c631e", bus.rk_data); end
                    checks++; if (bus.rk_last !== 1'b1) begin errors++; $display("FAIL a256_last got=%b exp=1", bus.rk_last); end
                end
                got++;
            end
            @(posedge clk); #1;
        end
        checks++; if (got != 15) begin errors++; $display("FAIL a256_count got=%0d exp=15", got); end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            checks++; if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL a256_extra_valid cycle=%0d got=%b exp=0", n, bus.rk_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int           cyc = 1;
        int           got = 0;
        logic         held = 1'b0;
        logic [127:0] h_data = '0;
        logic [3:0]   h_idx = '0;
        logic         h_last = 1'b0;
        send_key(KEY128, 2'd0);
        for (int n = 0; n < 800 && got < 11; n++) begin
            bus.rk_ready  = ($urandom_range(9, 0) < 3);
            bus.key_valid = (cyc >= 3 && cyc < 15);
            bus.key_in    = KEY256;
            bus.key_len   = 2'd2;
            @(negedge clk);
            if (held) begin
                checks++; if (bus.rk_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_drop r=%0d got=%b exp=1", got, bus.rk_valid); end
                checks++; if (bus.rk_data !== h_data || bus.rk_idx !== h_idx || bus.rk_last !== h_last) begin
                    errors++; $display("FAIL bp_stable got=%h/%0d/%b exp=%h/%0d/%b", bus.rk_data, bus.rk_idx, bus.rk_last, h_data, h_idx, h_last);
                end
            end
            if (bus.rk_valid && bus.rk_ready) begin
                checks++; if (bus.rk_idx !== 4'(got) || bus.rk_data !== EXP128[got]) begin
                    errors++; $display("FAIL bp_data r=%0d got=%0d/%h exp=%h", got, bus.rk_idx, bus.rk_data, EXP128[got]);
                end
                got++;
            end
            held   = bus.rk_valid && !bus.rk_ready;
            h_data = bus.rk_data;
            h_idx  = bus.rk_idx;
            h_last = bus.rk_last;
            @(posedge clk); #1;
            cyc++;
        end
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b1;
        checks++; if (got != 11) begin errors++; $display("FAIL bp_count got=%0d exp=11", got); end
        @(negedge clk);
        checks++; if (bus.rk_valid !== 1'b0 || bus.key_ready !== 1'b1) begin
            errors++; $display("FAIL bp_done got=valid %b ready %b exp=valid 0 ready 1", bus.rk_valid, bus.key_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        int got = 0;
        send_key(KEY128, 2'd3);
        @(negedge clk);
        checks++; if (bus.key_err !== 1'b1) begin errors++; $display("FAIL err_len3_pulse got=%b exp=1", bus.key_err); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.key_err !== 1'b0) begin errors++; $display("FAIL err_len3_width got=%b exp=0", bus.key_err); end
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (bus.rk_valid !== 1'b0 || bus.key_ready !== 1'b1) begin
                errors++; $display("FAIL err_len3_idle got=valid %b ready %b exp=valid 0 ready 1", bus.rk_valid, bus.key_ready);
            end
        end
        @(posedge clk); #1;
        bus4.key_in    = KEY256;
        bus4.key_len   = 2'd2;
        bus4.key_valid = 1'b1;
        @(posedge clk); #1;
        bus4.key_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus4.key_err !== 1'b1) begin errors++; $display("FAIL err_nk4_pulse got=%b exp=1", bus4.key_err); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus4.key_err !== 1'b0) begin errors++; $display("FAIL err_nk4_width got=%b exp=0", bus4.key_err); end
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (bus4.rk_valid !== 1'b0 || bus4.key_ready !== 1'b1) begin
                errors++; $display("FAIL err_nk4_idle got=valid %b ready %b exp=valid 0 ready 1", bus4.rk_valid, bus4.key_ready);
            end
        end
        @(posedge clk); #1;
        bus4.key_in    = KEY128;
        bus4.key_len   = 2'd0;
        bus4.key_valid = 1'b1;
        @(posedge clk); #1;
        bus4.key_valid = 1'b0;
        for (int n = 0; n < 80 && got < 11; n++) begin
            @(negedge clk);
            if (bus4.rk_valid) begin
                checks++; if (bus4.rk_data !== EXP128[got] || bus4.rk_idx !== 4'(got)) begin
                    errors++; $display("FAIL nk4_a128 r=%0d got=%0d/%h exp=%h", got, bus4.rk_idx, bus4.rk_data, EXP128[got]);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        checks++; if (got != 11) begin errors++; $display("FAIL nk4_count got=%0d exp=11", got); end
    endtask

    task automatic test_reset_midrun();
        int   got = 0;
        logic hit = 1'b0;
        bus.rk_ready = 1'b1;
        send_key(KEY128, 2'd0);
        for (int n = 0; n < 60 && !hit; n++) begin
            @(negedge clk);
            if (bus.rk_valid && bus.rk_idx == 4'd5) begin
                reset_n = 1'b0;
                hit     = 1'b1;
            end
            @(posedge clk); #1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_mid_reach got=no round 5 exp=round 5"); end
        @(negedge clk);
        checks++; if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", bus.rk_valid); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++; if (bus.rk_valid !== 1'b0 || bus.key_ready !== 1'b1) begin
                errors++; $display("FAIL rst_mid_idle got=valid %b ready %b exp=valid 0 ready 1", bus.rk_valid, bus.key_ready);
            end
            @(posedge clk); #1;
        end
        send_key(KEY128, 2'd0);
        for (int n = 0; n < 80 && got < 11; n++) begin
            @(negedge clk);
            if (bus.rk_valid) begin
                checks++; if (bus.rk_idx !== 4'(got) || bus.rk_data !== EXP128[got]) begin
                    errors++; $display("FAIL rst_mid_rerun r=%0d got=%0d/%h exp=%h", got, bus.rk_idx, bus.rk_data, EXP128[got]);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        checks++; if (got != 11) begin errors++; $display("FAIL rst_mid_count got=%0d exp=11", got); end
    endtask

    initial begin
        bus.key_in     = '0;
        bus.key_len    = '0;
        bus.key_valid  = 1'b0;
        bus.rk_ready   = 1'b0;
        bus4.key_in    = '0;
        bus4.key_len   = '0;
        bus4.key_valid = 1'b0;
        bus4.rk_ready  = 1'b1;
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_errors();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
